// File: rtl/ysyx_22041211_sram.sv
// Word-addressed memory responder for LSU load/store traffic with a configurable access delay.
// Define YSYX_22041211_SRAM_RAND_DELAY_EN to draw the delay (0..7) from an 8-bit LFSR instead of LATENCY.
module ysyx_22041211_sram #(
  parameter int unsigned          DATA_LEN   = 32,
  parameter int unsigned          DEPTH_LOG2 = 10,
  parameter logic [DATA_LEN-1:0]  BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned          LATENCY    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [DATA_LEN-1:0] req_addr_i,
  input  logic                req_wen_i,
  input  logic [DATA_LEN-1:0] req_wdata_i,
  input  logic [7:0]          req_wmask_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [DATA_LEN-1:0] resp_rdata_o,
  output logic                resp_err_o
);

  localparam int unsigned         WORDS = 1 << DEPTH_LOG2;
  localparam logic [DATA_LEN-1:0] SPAN  = DATA_LEN'(WORDS * 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q;
  logic [3:0]          delay;
  logic                accept;
  logic                access;

  logic [DATA_LEN-1:0] addr_q;
  logic                wen_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic [3:0]          mask_q;
  logic [DATA_LEN-1:0] rdata_q;
  logic                err_q;

  logic [31:0]         mem [WORDS];

  // Only the low four byte enables can address a 32-bit word.
  logic                unused_mask_hi;
  assign unused_mask_hi = ^req_wmask_i[7:4];

  assign accept = req_valid_i && req_ready_o;

`ifdef YSYX_22041211_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  // Taps for x^8+x^6+x^5+x^4+1; free-running so the delay depends on arrival cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign delay = {1'b0, lfsr_q[2:0]};
`else
  assign delay = 4'(LATENCY);
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path holds a
  // previous value, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept)           state_d = (delay == 4'd0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt_q <= 4'd1)    state_d = S_RESP;
      S_RESP: if (resp_ready_i)     state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    unique case (state_q)
      S_IDLE:  req_ready_o  = 1'b1;
      S_RESP:  resp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture and delay counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else if (state_q == S_IDLE && accept) begin
      cnt_q   <= delay;
      addr_q  <= req_addr_i;
      wen_q   <= req_wen_i;
      wdata_q <= req_wdata_i;
      mask_q  <= req_wmask_i[3:0];
    end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Access: a zero-delay request uses the live inputs, otherwise the latched copy
  // ---------------------------------------------------------------------------
  logic                use_live;
  logic [DATA_LEN-1:0] acc_addr;
  logic                acc_wen;
  logic [31:0]         acc_wdata;
  logic [3:0]          acc_mask;
  logic [DATA_LEN-1:0] off;
  logic                in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]          lane;
  logic [7:0]          be_wide;
  logic [3:0]          be;
  logic [31:0]         wword;
  logic [31:0]         rword;

  assign use_live  = (state_q == S_IDLE);
  assign access    = rst_n && ((use_live && accept && delay == 4'd0) ||
                               (state_q == S_WAIT && cnt_q <= 4'd1));

  assign acc_addr  = use_live ? req_addr_i        : addr_q;
  assign acc_wen   = use_live ? req_wen_i         : wen_q;
  assign acc_wdata = use_live ? req_wdata_i[31:0] : wdata_q[31:0];
  assign acc_mask  = use_live ? req_wmask_i[3:0]  : mask_q;

  assign off      = acc_addr - BASE_ADDR;
  assign in_range = (off < SPAN);
  assign idx      = off[DEPTH_LOG2+1:2];
  assign lane     = acc_addr[1:0];

  // Enables shifted beyond lane 3 fall off the top and are discarded.
  assign be_wide  = {4'b0000, acc_mask} << lane;
  assign be       = be_wide[3:0];
  assign wword    = acc_wdata << {lane, 3'b000};
  assign rword    = mem[idx] >> {lane, 3'b000};

  // NOTE: the array has no reset; contents survive rst_n like real memory,
  // and leaving it out lets the tools map it onto RAM.
  always_ff @(posedge clk) begin
    if (access && acc_wen && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (access) begin
      rdata_q <= (acc_wen || !in_range) ? '0 : DATA_LEN'(rword);
      err_q   <= !in_range;
    end
  end

  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_ysyx_22041211_sram.sv
// Directed bench for ysyx_22041211_sram: expected responses are queued at request time and popped on response.
module tb_ysyx_22041211_sram;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_wen = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [32:0] sb_q[$];
  int          lat;

  always #5 clk = ~clk;

  ysyx_22041211_sram #(
    .DATA_LEN   (32),
    .DEPTH_LOG2 (10),
    .BASE_ADDR  (32'h8000_0000),
    .LATENCY    (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_wen_i    (req_wen),
    .req_wdata_i  (req_wdata),
    .req_wmask_i  (req_wmask),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge, hold the response 'hold' cycles, then take it.
  task automatic do_req(input string tag, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [7:0] m,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int hold, output int lat_o);
    int          n;
    logic [32:0] exp;
    sb_q.push_back({exp_err, exp_rdata});
    req_addr  = a;
    req_wen   = w;
    req_wdata = d;
    req_wmask = m;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat_o = 1;
    if (!resp_valid) check({tag, "_busy"}, 32'(req_ready), 32'd0);
    while (!resp_valid && lat_o < 40) begin
      @(negedge clk);
      lat_o++;
    end
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
`ifndef YSYX_22041211_SRAM_RAND_DELAY_EN
    check({tag, "_lat"}, 32'(lat_o), 32'(LAT + 1));
`endif
    exp = sb_q.pop_front();
    check({tag, "_rdata"}, resp_rdata, exp[31:0]);
    check({tag, "_err"}, 32'(resp_err), 32'(exp[32]));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_hold_rdata"}, resp_rdata, exp[31:0]);
      check({tag, "_hold_err"}, 32'(resp_err), 32'(exp[32]));
      check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_done"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef YSYX_22041211_SRAM_RAND_DELAY_EN
  int lats[100];
`endif

  initial begin
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_req("sw",      32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 8'h0f, 32'h0,         1'b0, 0, lat);
    do_req("lw0",     32'h8000_0010, 1'b0, 32'h0,         8'h0f, 32'hDEAD_BEEF, 1'b0, 0, lat);
    do_req("sb",      32'h8000_0013, 1'b1, 32'h0000_0055, 8'h01, 32'h0,         1'b0, 0, lat);
    do_req("lw1",     32'h8000_0010, 1'b0, 32'h0,         8'h0f, 32'h55AD_BEEF, 1'b0, 0, lat);
    do_req("lb3",     32'h8000_0013, 1'b0, 32'h0,         8'h01, 32'h0000_0055, 1'b0, 0, lat);
    do_req("lh2",     32'h8000_0012, 1'b0, 32'h0,         8'h03, 32'h0000_55AD, 1'b0, 0, lat);
    do_req("sh3",     32'h8000_0013, 1'b1, 32'h0000_AA11, 8'h03, 32'h0,         1'b0, 0, lat);
    do_req("lw2",     32'h8000_0010, 1'b0, 32'h0,         8'h0f, 32'h11AD_BEEF, 1'b0, 0, lat);
    do_req("lb1",     32'h8000_0011, 1'b0, 32'h0,         8'h01, 32'h0011_ADBE, 1'b0, 0, lat);

    do_req("sw_lo",   32'h8000_0000, 1'b1, 32'hCAFE_F00D, 8'h0f, 32'h0,         1'b0, 0, lat);
    do_req("sw_hi",   32'h8000_0FFC, 1'b1, 32'h0BAD_C0DE, 8'h0f, 32'h0,         1'b0, 0, lat);
    do_req("oor_rlo", 32'h7FFF_FFFC, 1'b0, 32'h0,         8'h0f, 32'h0,         1'b1, 0, lat);
    do_req("oor_rhi", 32'h8000_1000, 1'b0, 32'h0,         8'h0f, 32'h0,         1'b1, 0, lat);
    do_req("oor_wlo", 32'h7FFF_FFFC, 1'b1, 32'hFFFF_FFFF, 8'h0f, 32'h0,         1'b1, 0, lat);
    do_req("oor_whi", 32'h8000_1000, 1'b1, 32'hFFFF_FFFF, 8'h0f, 32'h0,         1'b1, 0, lat);
    do_req("lw_lo",   32'h8000_0000, 1'b0, 32'h0,         8'h0f, 32'hCAFE_F00D, 1'b0, 0, lat);
    do_req("lw_hi",   32'h8000_0FFC, 1'b0, 32'h0,         8'h0f, 32'h0BAD_C0DE, 1'b0, 0, lat);
    do_req("lw_mid",  32'h8000_0010, 1'b0, 32'h0,         8'h0f, 32'h11AD_BEEF, 1'b0, 0, lat);

    do_req("bp",      32'h8000_0010, 1'b0, 32'h0,         8'h0f, 32'h11AD_BEEF, 1'b0, 5, lat);

`ifndef YSYX_22041211_SRAM_RAND_DELAY_EN
    // Reset lands while the write is still waiting for its access edge.
    req_addr  = 32'h8000_0010;
    req_wen   = 1'b1;
    req_wdata = 32'h1234_5678;
    req_wmask = 8'h0f;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("wait_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_rdata", resp_rdata, 32'd0);
    check("mid_rst_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(resp_valid), 32'd0);
    do_req("lw_old",  32'h8000_0010, 1'b0, 32'h0,         8'h0f, 32'h11AD_BEEF, 1'b0, 0, lat);
`else
    pulse_reset();
    for (int i = 0; i < 100; i++) begin
      do_req("rnd_a", 32'h8000_0010, 1'b0, 32'h0, 8'h0f, 32'h11AD_BEEF, 1'b0, 0, lat);
      lats[i] = lat;
      check("rnd_range", 32'(lat >= 1 && lat <= 8), 32'd1);
    end
    pulse_reset();
    for (int i = 0; i < 100; i++) begin
      do_req("rnd_b", 32'h8000_0010, 1'b0, 32'h0, 8'h0f, 32'h11AD_BEEF, 1'b0, 0, lat);
      check("rnd_repeat", 32'(lat), 32'(lats[i]));
    end
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
